// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, load opcodes and bus layouts for the MEM stage.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_BUS    = 6;
  localparam int STALL_MEM    = 3;
  localparam int STALL_WB     = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] MEM_OP_NONE = 3'b000;
  localparam logic [2:0] MEM_OP_LB   = 3'b001;
  localparam logic [2:0] MEM_OP_LBU  = 3'b010;
  localparam logic [2:0] MEM_OP_LH   = 3'b011;
  localparam logic [2:0] MEM_OP_LHU  = 3'b100;
  localparam logic [2:0] MEM_OP_LW   = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FRESH,
    ST_HELD
  } ld_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  mem_op;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic is_load(input ex_to_mem_t b);
    return b.data_ram_en && (b.data_ram_wen == 4'b0000);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts and extends the addressed byte/halfword of a loaded word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'b00:   w_byte = word[7:0];
      2'b01:   w_byte = word[15:8];
      2'b10:   w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    // addr[0] is deliberately ignored: misaligned halfwords read the containing half
    w_half = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (mem_op)
      MEM_OP_LB:  data = {{24{w_byte[7]}}, w_byte};
      MEM_OP_LBU: data = {24'h0, w_byte};
      MEM_OP_LH:  data = {{16{w_half[15]}}, w_half};
      MEM_OP_LHU: data = {16'h0, w_half};
      default:    data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: pipeline register, load-data hold FSM and writeback mux.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    mem_busy
);

  ex_to_mem_t r_ex;
  logic [31:0] r_hold;
  ld_state_e   r_state;

  ex_to_mem_t  w_ex_in;
  logic        w_bubble;
  logic        w_advance;
  logic [31:0] w_raw;
  logic [31:0] w_aligned;
  logic [31:0] w_wdata;
  logic        w_unused_stall;

  assign w_ex_in        = ex_to_mem_t'(ex_to_mem_bus);
  assign w_bubble       = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);
  assign w_advance      = (stall[STALL_MEM] == NO_STOP);
  assign w_unused_stall = ^{stall[STALL_BUS-1:STALL_WB+1], stall[STALL_MEM-1:0]};

  // SRAM data is only valid in the first MEM cycle, so a stalled load must latch it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex    <= '0;
      r_hold  <= '0;
      r_state <= ST_EMPTY;
    end else if (w_bubble) begin
      r_ex    <= '0;
      r_state <= ST_EMPTY;
    end else if (w_advance) begin
      r_ex    <= w_ex_in;
      r_state <= is_load(w_ex_in) ? ST_FRESH : ST_EMPTY;
    end else if (r_state == ST_FRESH) begin
      r_hold  <= data_sram_rdata;
      r_state <= ST_HELD;
    end
  end

  assign w_raw = (r_state == ST_HELD) ? r_hold : data_sram_rdata;

  load_align u_load_align (
    .mem_op (r_ex.mem_op),
    .addr   (r_ex.ex_result[1:0]),
    .word   (w_raw),
    .data   (w_aligned)
  );

  assign w_wdata       = r_ex.sel_rf_res ? w_aligned : r_ex.ex_result;
  assign mem_to_id_bus = {r_ex.rf_we, r_ex.rf_waddr, w_wdata};
  assign mem_to_wb_bus = {r_ex.pc, mem_to_id_bus};
  assign mem_busy      = (r_state == ST_HELD);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus stall/bubble/reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [STALL_BUS-1:0]    stall;
  ex_to_mem_t              ex_bus;
  logic [31:0]             rdata;
  logic [MEM_TO_WB_WD-1:0] wb_bus;
  logic [MEM_TO_ID_WD-1:0] id_bus;
  logic                    busy;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .ex_to_mem_bus   (ex_bus),
    .data_sram_rdata (rdata),
    .mem_to_wb_bus   (wb_bus),
    .mem_to_id_bus   (id_bus),
    .mem_busy        (busy)
  );

  typedef struct {
    string       name;
    ex_to_mem_t  ex;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    string       name;
    logic [69:0] wb;
    logic [37:0] id;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[14];

  function automatic ex_to_mem_t mk(input logic [31:0] pc, input logic [2:0] op,
                                    input logic en, input logic [3:0] wen, input logic sel,
                                    input logic we, input logic [4:0] waddr,
                                    input logic [31:0] res);
    ex_to_mem_t e;
    e.pc = pc; e.mem_op = op; e.data_ram_en = en; e.data_ram_wen = wen;
    e.sel_rf_res = sel; e.rf_we = we; e.rf_waddr = waddr; e.ex_result = res;
    return e;
  endfunction

  function automatic ex_to_mem_t ld(input logic [31:0] pc, input logic [2:0] op,
                                    input logic [31:0] addr, input logic [4:0] waddr);
    return mk(pc, op, 1'b1, 4'b0000, 1'b1, 1'b1, waddr, addr);
  endfunction

  task automatic push_exp(input string name, input ex_to_mem_t e, input logic [31:0] wdata,
                          input logic b);
    exp_t x;
    x.name = name;
    x.id   = {e.rf_we, e.rf_waddr, wdata};
    x.wb   = {e.pc, e.rf_we, e.rf_waddr, wdata};
    x.busy = b;
    sb_q.push_back(x);
  endtask

  task automatic cmp(input string name, input logic [69:0] act, input logic [69:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic check_out();
    exp_t x;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      x = sb_q.pop_front();
      cmp({x.name, ".wb"}, 70'(wb_bus), x.wb);
      cmp({x.name, ".id"}, 70'(id_bus), 70'(x.id));
      cmp({x.name, ".busy"}, 70'(busy), 70'(x.busy));
      $display("txn %-14s wb=%h id=%h busy=%0b", x.name, wb_bus, id_bus, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    ex_to_mem_t e;
    vecs[0]  = '{"lw_100",   ld(32'h1000, MEM_OP_LW,  32'h100, 5'd1),  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{"lb_a3",    ld(32'h1004, MEM_OP_LB,  32'h103, 5'd2),  32'h80FF1234, 32'hFFFFFF80};
    vecs[2]  = '{"lbu_a3",   ld(32'h1008, MEM_OP_LBU, 32'h103, 5'd3),  32'h80FF1234, 32'h00000080};
    vecs[3]  = '{"lhu_a2",   ld(32'h100C, MEM_OP_LHU, 32'h102, 5'd4),  32'h80FF1234, 32'h000080FF};
    vecs[4]  = '{"lh_a2",    ld(32'h1010, MEM_OP_LH,  32'h102, 5'd5),  32'h80FF1234, 32'hFFFF80FF};
    vecs[5]  = '{"lb_a0",    ld(32'h1014, MEM_OP_LB,  32'h100, 5'd6),  32'h80FF1234, 32'h00000034};
    vecs[6]  = '{"lb_a1",    ld(32'h1018, MEM_OP_LB,  32'h101, 5'd7),  32'h80FF1234, 32'h00000012};
    vecs[7]  = '{"lb_a2",    ld(32'h101C, MEM_OP_LB,  32'h102, 5'd8),  32'h80FF1234, 32'hFFFFFFFF};
    vecs[8]  = '{"lh_a1",    ld(32'h1020, MEM_OP_LH,  32'h101, 5'd9),  32'h80FF1234, 32'h00001234};
    vecs[9]  = '{"lw0_a3",   ld(32'h1024, MEM_OP_NONE, 32'h103, 5'd10), 32'h80FF1234, 32'h80FF1234};
    vecs[10] = '{"lhu_a0",   ld(32'h1028, MEM_OP_LHU, 32'h100, 5'd11), 32'h8001FFFE, 32'h0000FFFE};
    vecs[11] = '{"lh_a0",    ld(32'h102C, MEM_OP_LH,  32'h100, 5'd12), 32'h8001FFFE, 32'hFFFFFFFE};
    vecs[12] = '{"alu_42",
                 mk(32'h1030, MEM_OP_NONE, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd13, 32'h42),
                 32'hAAAAAAAA, 32'h00000042};
    vecs[13] = '{"store",
                 mk(32'h1034, MEM_OP_NONE, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0, 32'h200),
                 32'hAAAAAAAA, 32'h00000200};

    // Reset held with live inputs and a running clock: outputs must stay zero
    resetn = 1'b0;
    stall  = '0;
    rdata  = 32'h12345678;
    ex_bus = ld(32'h9000, MEM_OP_LW, 32'h44, 5'd3);
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_hold", '0, 32'h0, 1'b0);
    check_out();
    #2 resetn = 1'b1;
    ex_bus = '0;
    @(posedge clk); #1;
    push_exp("after_reset", '0, 32'h0, 1'b0);
    check_out();

    // Back-to-back vectors, no stall
    for (int i = 0; i < 14; i++) begin
      ex_bus = vecs[i].ex;
      push_exp(vecs[i].name, vecs[i].ex, vecs[i].exp_wdata, 1'b0);
      @(posedge clk); #1;
      rdata = vecs[i].rdata;
      #1;
      check_out();
    end
    ex_bus = '0;

    // Load stalled in MEM: data captured, SRAM bus changes afterwards
    e = ld(32'h400, MEM_OP_LW, 32'h10, 5'd5);
    ex_bus = e;
    @(posedge clk); #1;
    rdata = 32'h11223344;
    ex_bus = ld(32'h404, MEM_OP_LW, 32'h14, 5'd6);
    stall[STALL_MEM] = STOP;
    stall[STALL_WB]  = STOP;
    push_exp("hold_fresh", e, 32'h11223344, 1'b0);
    #1 check_out();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rdata = 32'hAAAAAAAA;
      push_exp($sformatf("hold_%0d", k), e, 32'h11223344, 1'b1);
      #1 check_out();
    end
    stall  = '0;
    ex_bus = '0;
    @(posedge clk); #1;
    push_exp("hold_release", '0, 32'h0, 1'b0);
    check_out();

    // Bubble while a load is fresh: capture discarded, FSM empties
    e = ld(32'h500, MEM_OP_LB, 32'h3, 5'd7);
    ex_bus = e;
    @(posedge clk); #1;
    rdata = 32'h7F000000;
    ex_bus = ld(32'h504, MEM_OP_LW, 32'h8, 5'd8);
    stall[STALL_MEM] = STOP;
    stall[STALL_WB]  = NO_STOP;
    push_exp("bub_fresh", e, 32'h0000007F, 1'b0);
    #1 check_out();
    @(posedge clk); #1;
    push_exp("bubble", '0, 32'h0, 1'b0);
    #1 check_out();
    stall[STALL_WB] = STOP;
    @(posedge clk); #1;
    push_exp("bubble_empty", '0, 32'h0, 1'b0);
    #1 check_out();
    stall  = '0;
    ex_bus = '0;

    // Asynchronous reset while HELD, then a normal load
    e = ld(32'h600, MEM_OP_LW, 32'h20, 5'd9);
    ex_bus = e;
    @(posedge clk); #1;
    rdata = 32'hCAFEF00D;
    ex_bus = '0;
    stall[STALL_MEM] = STOP;
    stall[STALL_WB]  = STOP;
    push_exp("rst_fresh", e, 32'hCAFEF00D, 1'b0);
    #1 check_out();
    @(posedge clk); #1;
    rdata = 32'h55555555;
    push_exp("rst_held", e, 32'hCAFEF00D, 1'b1);
    #1 check_out();
    #1 resetn = 1'b0;
    #1;
    push_exp("rst_async", '0, 32'h0, 1'b0);
    check_out();
    stall = '0;
    @(posedge clk); #2;
    resetn = 1'b1;
    e = ld(32'h700, MEM_OP_LW, 32'h100, 5'd1);
    ex_bus = e;
    push_exp("lw_after_rst", e, 32'hDEADBEEF, 1'b0);
    @(posedge clk); #1;
    rdata = 32'hDEADBEEF;
    ex_bus = '0;
    #1 check_out();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
